// File: rtl/surprise_hit_detector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | surprise_hit_detector_pkg : shared state encoding and surprise-count default |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package surprise_hit_detector_pkg;

  localparam int NUM_SURPRISES_DEF = 8;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    CAPTURED = 2'd1,
    REPORT   = 2'd2,
    HOLD     = 2'd3
  } hitState_t;

endpackage
`default_nettype wire

// File: rtl/lsb_onehot_priority.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsb_onehot_priority : isolates the lowest set bit and encodes its index     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module lsb_onehot_priority #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] reqVec,
  output logic [WIDTH-1:0] oneHot,
  output logic [IDX_W-1:0] index
);

  // Two's-complement trick: x & -x keeps only the lowest set bit.
  assign oneHot = reqVec & (~reqVec + WIDTH'(1));

  always_comb begin
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (reqVec[i]) index = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/surprise_hit_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | surprise_hit_detector : captures one Bumpy/surprise overlap per frame and   |
// | reports it at the next frame start as a pulse plus a held one-hot bus.     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module surprise_hit_detector
  import surprise_hit_detector_pkg::*;
#(
  parameter int NUM_SURPRISES = NUM_SURPRISES_DEF,
  parameter int HOLD_CYCLES   = 2,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     bumpyDrawingRequest,
  input  logic [NUM_SURPRISES-1:0] surpriseDrawingReq,
  input  logic [NUM_SURPRISES-1:0] enable_all,
  output logic                     SHP_bumpySurprise,
  output logic [NUM_SURPRISES-1:0] surprise_bus,
  output logic [2:0]               hit_ID,
  output logic [CNT_W-1:0]         hit_count
);

  hitState_t                state;
  logic [NUM_SURPRISES-1:0] cap;
  logic [3:0]               holdCnt;
  logic [NUM_SURPRISES-1:0] overlap;
  logic [NUM_SURPRISES-1:0] encIn;
  logic [NUM_SURPRISES-1:0] winOneHot;
  logic [2:0]               winIdx;

  assign overlap = surpriseDrawingReq & enable_all & {NUM_SURPRISES{bumpyDrawingRequest}};

  // One encoder serves both jobs: picking the winner while ARMED, encoding cap afterwards.
  assign encIn = (state == ARMED) ? overlap : cap;

  lsb_onehot_priority #(
    .WIDTH (NUM_SURPRISES),
    .IDX_W (3)
  ) uPriority (
    .reqVec (encIn),
    .oneHot (winOneHot),
    .index  (winIdx)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state             <= ARMED;
      cap               <= '0;
      holdCnt           <= '0;
      SHP_bumpySurprise <= 1'b0;
      surprise_bus      <= '0;
      hit_ID            <= '0;
      hit_count         <= '0;
    end else begin
      case (state)
        ARMED: begin
          // A frame-start cycle wins over a coincident overlap.
          if (!startOfFrame && (|overlap)) begin
            cap   <= winOneHot;
            state <= CAPTURED;
          end
        end
        CAPTURED: begin
          if (startOfFrame) begin
            SHP_bumpySurprise <= 1'b1;
            surprise_bus      <= cap;
            hit_ID            <= winIdx;
            if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + CNT_W'(1);
            state             <= REPORT;
          end
        end
        REPORT: begin
          SHP_bumpySurprise <= 1'b0;
          holdCnt           <= 4'(HOLD_CYCLES - 1);
          state             <= HOLD;
        end
        HOLD: begin
          if (holdCnt == 4'd0) begin
            surprise_bus <= '0;
            hit_ID       <= '0;
            cap          <= '0;
            state        <= ARMED;
          end else begin
            holdCnt <= holdCnt - 4'd1;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_surprise_hit_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_surprise_hit_detector : directed and random frames against a hit model   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_surprise_hit_detector;

  localparam int H  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          sof = 1'b0;
  logic          bumpy = 1'b0;
  logic [7:0]    req = 8'h00;
  logic [7:0]    en = 8'hFF;
  logic          pulse;
  logic [7:0]    bus;
  logic [2:0]    hid;
  logic [CW-1:0] cnt;

  int checks = 0;
  int failures = 0;

  // Model: pending captured index, displayed index, cycles of bus visibility left.
  int mPend = -1;
  int mShown = -1;
  int mLeft = 0;
  int mPulse = 0;
  int mCount = 0;

  surprise_hit_detector #(
    .NUM_SURPRISES (8),
    .HOLD_CYCLES   (H),
    .CNT_W         (CW)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (sof),
    .bumpyDrawingRequest (bumpy),
    .surpriseDrawingReq  (req),
    .enable_all          (en),
    .SHP_bumpySurprise   (pulse),
    .surprise_bus        (bus),
    .hit_ID              (hid),
    .hit_count           (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPend = -1; mShown = -1; mLeft = 0; mPulse = 0; mCount = 0;
  endtask

  task automatic checkOutputs();
    chk("pulse", {31'd0, pulse}, mPulse);
    chk("bus", {24'd0, bus}, (mShown < 0) ? 0 : (1 << mShown));
    chk("hit_ID", {29'd0, hid}, (mShown < 0) ? 0 : mShown);
    chk("hit_count", {{(32-CW){1'b0}}, cnt}, mCount);
  endtask

  task automatic modelEdge(input bit s, input bit b, input logic [7:0] r, input logic [7:0] e);
    logic [7:0] ov;
    mPulse = 0;
    if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) mShown = -1;
    end else if (mPend >= 0) begin
      if (s) begin
        mShown = mPend;
        mPend  = -1;
        mLeft  = H + 1;
        mPulse = 1;
        if (mCount < (1 << CW) - 1) mCount++;
      end
    end else if (!s && b) begin
      ov = r & e;
      for (int i = 0; i < 8; i++) begin
        if (ov[i]) begin
          mPend = i;
          break;
        end
      end
    end
  endtask

  // Drive one pixel from a negedge, let the posedge sample it, check at the next negedge.
  task automatic pix(input bit s, input bit b, input logic [7:0] r, input logic [7:0] e);
    sof = s; bumpy = b; req = r; en = e;
    @(posedge clk);
    modelEdge(s, b, r, e);
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 8'h00, 8'hFF);
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    checkOutputs();
    @(negedge clk);
    resetN = 1'b1;

    // Single hit at pixel 100, reported on the next frame start.
    pix(1'b1, 1'b0, 8'h00, 8'hFF);
    idle(99);
    pix(1'b0, 1'b1, 8'h04, 8'hFF);
    idle(10);
    pix(1'b1, 1'b0, 8'h00, 8'hFF);
    chk("single_pulse", {31'd0, pulse}, 1);
    chk("single_bus", {24'd0, bus}, 32'h04);
    chk("single_id", {29'd0, hid}, 2);
    idle(6);

    // Multi-overlap: lowest bit wins.
    pix(1'b0, 1'b1, 8'hA0, 8'hFF);
    idle(3);
    pix(1'b1, 1'b0, 8'h00, 8'hFF);
    chk("multi_bus", {24'd0, bus}, 32'h20);
    chk("multi_id", {29'd0, hid}, 5);
    idle(6);

    // Masked surprise over three frames.
    for (int f = 0; f < 3; f++) begin
      pix(1'b1, 1'b0, 8'h00, 8'hFE);
      pix(1'b0, 1'b1, 8'h01, 8'hFE);
      idle(5);
    end
    chk("masked_count", {{(32-CW){1'b0}}, cnt}, 2);

    // Overlap coincident with frame start is dropped; one cycle later it is kept.
    pix(1'b1, 1'b1, 8'h02, 8'hFF);
    idle(4);
    pix(1'b1, 1'b0, 8'h00, 8'hFF);
    chk("boundary_nopulse", {31'd0, pulse}, 0);
    pix(1'b0, 1'b1, 8'h02, 8'hFF);
    idle(3);
    pix(1'b1, 1'b0, 8'h00, 8'hFF);
    chk("boundary_bus", {24'd0, bus}, 32'h02);
    idle(6);

    // Second hit in the same frame is not reported.
    pix(1'b0, 1'b1, 8'h01, 8'hFF);
    pix(1'b0, 1'b1, 8'h08, 8'hFF);
    pix(1'b1, 1'b0, 8'h00, 8'hFF);
    chk("second_bus", {24'd0, bus}, 32'h01);
    idle(5);
    pix(1'b1, 1'b0, 8'h00, 8'hFF);
    chk("second_nopulse", {31'd0, pulse}, 0);
    idle(3);

    // Asynchronous reset in the middle of HOLD.
    pix(1'b0, 1'b1, 8'h10, 8'hFF);
    pix(1'b1, 1'b0, 8'h00, 8'hFF);
    pix(1'b0, 1'b0, 8'h00, 8'hFF);
    #2 resetN = 1'b0;
    #1;
    modelReset();
    checkOutputs();
    @(negedge clk);
    resetN = 1'b1;
    checkOutputs();
    pix(1'b0, 1'b1, 8'h40, 8'hFF);
    pix(1'b1, 1'b0, 8'h00, 8'hFF);
    chk("post_reset_bus", {24'd0, bus}, 32'h40);
    chk("post_reset_count", {{(32-CW){1'b0}}, cnt}, 1);
    idle(5);

    // Random frames, including overlaps on frame-start cycles.
    for (int f = 0; f < 80; f++) begin
      int len;
      len = 6 + int'($urandom_range(10));
      for (int p = 0; p < len; p++) begin
        logic [7:0] r;
        logic [7:0] e;
        bit         b;
        r = 8'($urandom) & 8'($urandom);
        e = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
        b = ($urandom_range(3) == 0);
        pix(p == 0, b, r, e);
      end
    end

    // Guaranteed hits every frame to drive the counter into saturation.
    for (int f = 0; f < 20; f++) begin
      pix(1'b1, 1'b0, 8'h00, 8'hFF);
      pix(1'b0, 1'b1, 8'h80, 8'hFF);
      idle(4);
    end
    chk("saturate", {{(32-CW){1'b0}}, cnt}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
